// File: rtl/memory_round_ctrl.sv
// Round sequencer for the keypad memorization game: fetches a 4-digit BCD
// sequence, times its display by difficulty, checks keypad entry and keeps score.
module memory_round_ctrl #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned EASY_TICKS    = 7000000,
    parameter int unsigned MED_TICKS     = 5000000,
    parameter int unsigned HARD_TICKS    = 3000000,
    parameter int unsigned TIMEOUT_TICKS = 200000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        seq_req,
    input  logic        seq_ack,
    input  logic [19:0] seq_data,
    output logic        show_number,
    output logic [19:0] disp_value,
    output logic [13:0] score,
    output logic [1:0]  difficulty,
    output logic [2:0]  state,
    output logic [2:0]  digit_count,
    output logic        round_pass,
    output logic        round_fail
);

    localparam int unsigned MAX_SHOW  = (EASY_TICKS > MED_TICKS)
                                        ? ((EASY_TICKS > HARD_TICKS) ? EASY_TICKS : HARD_TICKS)
                                        : ((MED_TICKS > HARD_TICKS) ? MED_TICKS : HARD_TICKS);
    localparam int unsigned MAX_TICKS = (MAX_SHOW > TIMEOUT_TICKS) ? MAX_SHOW : TIMEOUT_TICKS;
    localparam int unsigned TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TIMER_W-1:0] EASY_LOAD    = TIMER_W'(EASY_TICKS - 1);
    localparam logic [TIMER_W-1:0] MED_LOAD     = TIMER_W'(MED_TICKS - 1);
    localparam logic [TIMER_W-1:0] HARD_LOAD    = TIMER_W'(HARD_TICKS - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_TICKS - 1);
    localparam logic [2:0]         LAST_DIGIT   = 3'(DIGITS - 1);
    localparam logic [13:0]        SCORE_MAX    = 14'd9999;
    localparam logic [3:0]         KEY_START    = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHOW  = 3'd2,
        INPUT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t             state_q;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] show_load_c;
    logic [3:0]         expected_digit_c;

    assign state = state_q;

    // Display window length for the selected difficulty; code 11 falls back to EASY.
    always_comb begin
        show_load_c = EASY_LOAD;
        case (difficulty)
            2'b01:   show_load_c = MED_LOAD;
            2'b10:   show_load_c = HARD_LOAD;
            default: show_load_c = EASY_LOAD;
        endcase
    end

    // Digit expected next, most significant nibble first.
    always_comb begin
        expected_digit_c = disp_value[15:12];
        case (digit_count[1:0])
            2'd1:    expected_digit_c = disp_value[11:8];
            2'd2:    expected_digit_c = disp_value[7:4];
            2'd3:    expected_digit_c = disp_value[3:0];
            default: expected_digit_c = disp_value[15:12];
        endcase
    end

    // Timer is shared: show window in SHOW, inactivity timeout in INPUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            difficulty  <= 2'b00;
            score       <= 14'd0;
            digit_count <= 3'd0;
            disp_value  <= 20'd0;
            seq_req     <= 1'b0;
            show_number <= 1'b0;
            round_pass  <= 1'b0;
            round_fail  <= 1'b0;
            timer       <= '0;
        end else begin
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        case (key_code)
                            4'h1: difficulty <= 2'b00;
                            4'h2: difficulty <= 2'b01;
                            4'h3: difficulty <= 2'b10;
                            KEY_START: begin
                                score       <= 14'd0;
                                digit_count <= 3'd0;
                                seq_req     <= 1'b1;
                                state_q     <= FETCH;
                            end
                            default: ;
                        endcase
                    end
                end
                FETCH: begin
                    if (seq_req && seq_ack) begin
                        disp_value  <= seq_data;
                        timer       <= show_load_c;
                        seq_req     <= 1'b0;
                        show_number <= 1'b1;
                        state_q     <= SHOW;
                    end
                end
                SHOW: begin
                    if (timer == '0) begin
                        show_number <= 1'b0;
                        digit_count <= 3'd0;
                        timer       <= TIMEOUT_LOAD;
                        state_q     <= INPUT;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                INPUT: begin
                    // A key in the expiry cycle wins over the timeout.
                    if (key_valid) begin
                        if (key_code == expected_digit_c) begin
                            digit_count <= digit_count + 3'd1;
                            timer       <= TIMEOUT_LOAD;
                            if (digit_count == LAST_DIGIT) begin
                                round_pass <= 1'b1;
                                if (score < SCORE_MAX) begin
                                    score <= score + 14'd1;
                                end
                                seq_req <= 1'b1;
                                state_q <= FETCH;
                            end
                        end else begin
                            round_fail <= 1'b1;
                            state_q    <= OVER;
                        end
                    end else if (timer == '0) begin
                        round_fail <= 1'b1;
                        state_q    <= OVER;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                OVER: begin
                    if (key_valid && (key_code == KEY_START)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    seq_req     <= 1'b0;
                    show_number <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Directed bench for memory_round_ctrl; a second instance with one-cycle
// show windows is driven through 10000 rounds to reach score saturation.
module tb_memory_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        key_valid = 1'b0;
    logic [3:0]  key_code  = 4'h0;
    logic        seq_ack   = 1'b0;
    logic [19:0] seq_data  = 20'h0;
    logic        seq_req, show_number, round_pass, round_fail;
    logic [19:0] disp_value;
    logic [13:0] score;
    logic [1:0]  difficulty;
    logic [2:0]  state, digit_count;

    logic        s_key_valid = 1'b0;
    logic [3:0]  s_key_code  = 4'h0;
    logic        s_seq_ack   = 1'b0;
    logic [19:0] s_seq_data  = 20'h0;
    logic        s_seq_req, s_show_number, s_round_pass, s_round_fail;
    logic [19:0] s_disp_value;
    logic [13:0] s_score;
    logic [1:0]  s_difficulty;
    logic [2:0]  s_state, s_digit_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_round_ctrl #(
        .DIGITS(4), .EASY_TICKS(7), .MED_TICKS(5), .HARD_TICKS(3), .TIMEOUT_TICKS(20)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .seq_req(seq_req), .seq_ack(seq_ack), .seq_data(seq_data),
        .show_number(show_number), .disp_value(disp_value), .score(score),
        .difficulty(difficulty), .state(state), .digit_count(digit_count),
        .round_pass(round_pass), .round_fail(round_fail)
    );

    memory_round_ctrl #(
        .DIGITS(4), .EASY_TICKS(1), .MED_TICKS(1), .HARD_TICKS(1), .TIMEOUT_TICKS(20)
    ) u_sat (
        .clk(clk), .rst(rst), .key_valid(s_key_valid), .key_code(s_key_code),
        .seq_req(s_seq_req), .seq_ack(s_seq_ack), .seq_data(s_seq_data),
        .show_number(s_show_number), .disp_value(s_disp_value), .score(s_score),
        .difficulty(s_difficulty), .state(s_state), .digit_count(s_digit_count),
        .round_pass(s_round_pass), .round_fail(s_round_fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic ack(input logic [19:0] d);
        seq_ack  = 1'b1;
        seq_data = d;
        tick();
        seq_ack  = 1'b0;
    endtask

    initial begin
        int cnt;
        int early;

        // Reset values
        #12;
        check("rst_state", state, 0);
        check("rst_diff", difficulty, 0);
        check("rst_score", score, 0);
        check("rst_count", digit_count, 0);
        check("rst_disp", disp_value, 0);
        check("rst_req", seq_req, 0);
        check("rst_show", show_number, 0);
        check("rst_pass", round_pass, 0);
        check("rst_fail", round_fail, 0);
        rst = 1'b0;
        tick();

        // Stray ack in IDLE
        ack(20'h0ABCD);
        check("stray_state", state, 0);
        check("stray_disp", disp_value, 0);

        // Select MEDIUM and start
        send_key(4'h2);
        check("diff_med", difficulty, 1);
        check("diff_idle", state, 0);
        send_key(4'hF);
        check("start_state", state, 1);
        check("start_req", seq_req, 1);

        // Key during FETCH ignored, difficulty locked
        send_key(4'h1);
        check("fetch_key_state", state, 1);
        check("fetch_key_diff", difficulty, 1);
        early = 0;
        repeat (4) begin
            tick();
            if (seq_req !== 1'b1) early++;
        end
        check("req_held", early, 0);
        ack(20'h01234);
        check("show_state", state, 2);
        check("show_req_low", seq_req, 0);
        check("show_disp", disp_value, 32'h01234);

        // Count show window with a key pressed in its first cycle
        cnt = 0;
        key_valid = 1'b1;
        key_code  = 4'hF;
        while (show_number && cnt < 20) begin
            cnt++;
            tick();
            key_valid = 1'b0;
        end
        check("show_cycles", cnt, 5);
        check("input_state", state, 3);
        check("input_count", digit_count, 0);

        // Correct round
        send_key(4'h1); check("cnt1", digit_count, 1);
        send_key(4'h2); check("cnt2", digit_count, 2);
        send_key(4'h3); check("cnt3", digit_count, 3);
        send_key(4'h4);
        check("cnt4", digit_count, 4);
        check("pass_pulse", round_pass, 1);
        check("pass_nofail", round_fail, 0);
        check("pass_score", score, 1);
        check("pass_state", state, 1);
        check("pass_req", seq_req, 1);
        tick();
        check("pass_one_cycle", round_pass, 0);

        // Mismatch round
        ack(20'h05678);
        repeat (5) tick();
        check("mm_input", state, 3);
        check("mm_count0", digit_count, 0);
        send_key(4'h5);
        check("mm_cnt1", digit_count, 1);
        send_key(4'h9);
        check("mm_fail", round_fail, 1);
        check("mm_nopass", round_pass, 0);
        check("mm_state", state, 4);
        check("mm_score", score, 1);
        check("mm_count_hold", digit_count, 1);
        tick();
        check("mm_fail_one", round_fail, 0);
        send_key(4'h0);
        check("over_ignore", state, 4);
        send_key(4'hF);
        check("over_idle", state, 0);
        check("over_score", score, 1);

        // Timeout with no key, HARD difficulty, ack in the same cycle req rises
        send_key(4'h3);
        check("diff_hard", difficulty, 2);
        send_key(4'hF);
        check("restart_score", score, 0);
        ack(20'h04321);
        repeat (3) tick();
        check("to_input", state, 3);
        early = 0;
        repeat (19) begin
            tick();
            if (round_fail) early++;
        end
        check("to_no_early", early, 0);
        tick();
        check("to_fail", round_fail, 1);
        check("to_state", state, 4);
        send_key(4'hF);
        send_key(4'hF);
        ack(20'h04321);
        repeat (3) tick();
        check("to2_input", state, 3);

        // Key in the expiry cycle wins, then timeout restarts from acceptance
        repeat (19) tick();
        send_key(4'h4);
        check("tokey_nofail", round_fail, 0);
        check("tokey_count", digit_count, 1);
        check("tokey_state", state, 3);
        early = 0;
        repeat (19) begin
            tick();
            if (round_fail) early++;
        end
        check("reload_no_early", early, 0);
        tick();
        check("reload_fail", round_fail, 1);
        send_key(4'hF);
        check("reload_idle", state, 0);

        // Asynchronous reset mid-SHOW
        send_key(4'hF);
        ack(20'h09876);
        check("ar_show", show_number, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_show_low", show_number, 0);
        check("ar_state", state, 0);
        check("ar_disp", disp_value, 0);
        check("ar_diff", difficulty, 0);
        check("ar_req", seq_req, 0);
        check("ar_count", digit_count, 0);
        #2 rst = 1'b0;
        tick();

        // Score saturation on the fast instance
        s_key_valid = 1'b1;
        s_key_code  = 4'hF;
        tick();
        s_key_valid = 1'b0;
        for (int r = 0; r < 10000; r++) begin
            s_seq_ack  = 1'b1;
            s_seq_data = 20'h01234;
            tick();
            s_seq_ack  = 1'b0;
            tick();
            for (int d = 1; d <= 4; d++) begin
                s_key_valid = 1'b1;
                s_key_code  = 4'(d);
                tick();
            end
            s_key_valid = 1'b0;
            if (r == 9998) check("sat_reach", s_score, 9999);
        end
        check("sat_hold", s_score, 9999);
        check("sat_pass", s_round_pass, 1);
        check("sat_state", s_state, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_round_ctrl.md
# memory_round_ctrl

Round sequencer for the keypad memorization game. It requests a 4-digit BCD sequence from the sequence source over a req/ack handshake, then times the display window by difficulty. It checks keypad entries digit by digit as they arrive, with an inactivity timeout, and maintains a saturating score. It sits between the keypad front end (synchronized one-cycle key pulses) and the VGA/7-segment/sequence-provider blocks, replacing ad-hoc sequencing in the top level.

## Interface
- DIGITS, 4: digits per round; fixed at 4 (20-bit sequence, 5 nibbles with the top nibble unused/ignored).
- EASY_TICKS, 7000000: show_number duration in EASY, in clk cycles.
- MED_TICKS, 5000000: show_number duration in MEDIUM.
- HARD_TICKS, 3000000: show_number duration in HARD.
- TIMEOUT_TICKS, 200000000: maximum clk cycles allowed between digit entries in INPUT.
- Reset is `rst`, asynchronous, active-high; the clock is `clk`.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- key_valid  in  1  one-cycle pulse; key_code valid this cycle.
- key_code  in  4  keypad value (0x0–0xF).
- seq_req  out  1  request for a new sequence.
- seq_ack  in  1  sequence source acknowledge; seq_data valid when high.
- seq_data  in  20  sequence; digits at [15:12],[11:8],[7:4],[3:0], most significant first.
- show_number  out  1  high while the sequence is to be drawn on VGA.
- disp_value  out  20  captured sequence, for VGA.
- score  out  14  binary score, 0–9999, for the 7-segment display.
- difficulty  out  2  00 EASY, 01 MEDIUM, 10 HARD.
- state  out  3  current FSM state encoding.
- digit_count  out  3  digits correctly entered this round (0–4).
- round_pass  out  1  one-cycle pulse on a correct round.
- round_fail  out  1  one-cycle pulse on a mismatch or timeout.

## Operation
- States: IDLE=0, FETCH=1, SHOW=2, INPUT=3, OVER=4. Codes 5–7 go to IDLE on the next clock.
- IDLE:
  - key 1/2/3 sets difficulty to EASY/MEDIUM/HARD.
  - key 0xF clears score to 0 and enters FETCH.
  - Other keys are ignored.
- FETCH:
  - seq_req is high.
  - On a cycle with seq_req&&seq_ack: capture seq_data into disp_value, load the show timer with the difficulty's ticks, and enter SHOW. seq_req is low from the next cycle.
  - Keys are ignored.
- SHOW:
  - show_number is high.
  - The timer decrements each cycle. When it reaches its terminal count, show_number goes low and the FSM enters INPUT with digit_count=0 and the timeout counter loaded.
  - Keys are ignored.
- INPUT:
  - Expected digit is disp_value nibble [15-4*digit_count -: 4].
  - A matching key increments digit_count and reloads the timeout. When digit_count reaches 4: pulse round_pass, increment score (saturating at 9999), and enter FETCH.
  - A mismatching key pulses round_fail and enters OVER.
  - If the timeout expires with no key, pulse round_fail and enter OVER.
- OVER:
  - score and digit_count hold.
  - key 0xF enters IDLE. score is retained until the next start.
- difficulty changes only in IDLE. An invalid code 11 behaves as EASY.

## Timing
- Reset values:
  - state=IDLE, difficulty=EASY.
  - score=0, digit_count=0, disp_value=0.
  - seq_req=0, show_number=0, round_pass=0, round_fail=0.
- All outputs are registered.
- Start key at cycle t (IDLE) gives state=FETCH and seq_req=1 at t+1.
- seq_ack may arrive in the same cycle seq_req first rises, or any number of cycles later. The controller holds seq_req until ack. Ack while seq_req=0 is ignored.
- Ack at cycle a gives show_number=1 from a+1 through a+N inclusive (exactly N cycles, N = difficulty ticks). state=INPUT at a+N+1.
- Key at cycle k in INPUT updates digit_count/state/pulses at k+1.
- After the 4th correct key, state=FETCH and seq_req=1 at k+1.
- Timeout: round_fail is asserted exactly TIMEOUT_TICKS cycles after INPUT entry or the last accepted digit, if no key_valid arrives in between.
- A key_valid arriving in the same cycle the timeout would expire takes priority: the key is evaluated and the timeout is ignored.
- round_pass and round_fail are never high together. Each is high for exactly one cycle.
- Score at 9999 plus a pass stays 9999.
- Asynchronous reset mid-FETCH drops seq_req immediately. The sequence source must tolerate an abandoned request.

## Test plan
- Use EASY/MED/HARD_TICKS=7/5/3 and TIMEOUT_TICKS=20.
- Difficulty select and start: key 2, then key F, then ack with 0x01234 → show_number high for exactly 5 cycles, disp_value=0x01234, state=INPUT.
- Correct round: keys 1,2,3,4 → digit_count steps 1→4, round_pass pulses once, score=1, seq_req=1 on the next cycle.
- Mismatch: sequence 0x05678, keys 5,9 → round_fail pulse on the 2nd key, state=OVER, score unchanged; key F → IDLE.
- Timeout: enter INPUT, no key for 20 cycles → round_fail at cycle 20. Key at cycle 20 instead → digit evaluated, no fail.
- Handshake and ignore rules:
  - Delayed ack (5 cycles): seq_req held throughout.
  - Keys during FETCH and SHOW produce no state change.
  - Stray ack in IDLE is ignored.
- Saturation and reset: force score to 9999, then pass a round → score stays 9999. Assert rst mid-SHOW → all outputs return to their reset values asynchronously.
